// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: collects two operands and an operator, then captures the datapath result.
// Optional macro CALC_CHAIN_EN lets an operator pressed on a shown result start a new calculation from it.
module calc_sequencer (
  input  logic        IN_clk,
  input  logic        IN_reset,
  input  logic        IN_digit_valid,
  input  logic [3:0]  IN_digit,
  input  logic        IN_op_valid,
  input  logic [2:0]  IN_op_code,
  input  logic        IN_equals,
  input  logic        IN_clear,
  input  logic [31:0] IN_answer,
  input  logic        IN_is_negative,
  output logic [15:0] OUT_num1,
  output logic [15:0] OUT_num2,
  output logic [2:0]  OUT_operation_code,
  output logic [31:0] OUT_display,
  output logic        OUT_display_negative,
  output logic [1:0]  OUT_state,
  output logic        OUT_entry_error
);

  localparam logic [1:0] S_NUM1   = 2'd0;
  localparam logic [1:0] S_NUM2   = 2'd1;
  localparam logic [1:0] S_CALC   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  logic [1:0]  state;
  logic [15:0] num1;
  logic [15:0] num2;
  logic [2:0]  op;
  logic [31:0] result;
  logic        sign;
  logic        entry_error;
  logic        num2_has_digit;

  // Input strobes are single-cycle pulses with no back-pressure: each is consumed
  // (or dropped by priority clear > equals > operator > digit) on the edge it is seen.
  logic [15:0] entry;
  logic [19:0] entry_next;
  logic        digit_ok;
  logic        op_onehot;

  assign entry      = (state == S_NUM2) ? num2 : num1;
  assign entry_next = ({4'b0, entry} * 20'd10) + {16'b0, IN_digit};
  assign digit_ok   = (IN_digit <= 4'd9) && (entry_next <= 20'd65535);
  assign op_onehot  = (IN_op_code == 3'b001) || (IN_op_code == 3'b010) ||
                      (IN_op_code == 3'b100);

  always_ff @(posedge IN_clk) begin
    if (IN_reset || IN_clear) begin
      state          <= S_NUM1;
      num1           <= 16'd0;
      num2           <= 16'd0;
      op             <= 3'b000;
      result         <= 32'd0;
      sign           <= 1'b0;
      entry_error    <= 1'b0;
      num2_has_digit <= 1'b0;
    end else begin
      entry_error <= 1'b0;
      if (state == S_CALC) begin
        result <= IN_answer;
        sign   <= IN_is_negative;
        state  <= S_RESULT;
      end else if (IN_equals) begin
        if (state == S_NUM2) state <= S_CALC;
      end else if (IN_op_valid) begin
        if (!op_onehot) begin
          entry_error <= 1'b1;
        end else begin
          case (state)
            S_NUM1: begin
              op             <= IN_op_code;
              num2           <= 16'd0;
              num2_has_digit <= 1'b0;
              state          <= S_NUM2;
            end
            S_NUM2: begin
              if (!num2_has_digit) op <= IN_op_code;
            end
            S_RESULT: begin
`ifdef CALC_CHAIN_EN
              if (!sign && (result <= 32'd65535)) begin
                num1           <= result[15:0];
                op             <= IN_op_code;
                num2           <= 16'd0;
                num2_has_digit <= 1'b0;
                state          <= S_NUM2;
              end else begin
                entry_error <= 1'b1;
              end
`else
              entry_error <= 1'b0;
`endif
            end
            default: ;
          endcase
        end
      end else if (IN_digit_valid) begin
        case (state)
          S_NUM1: begin
            if (digit_ok) num1 <= entry_next[15:0];
            else          entry_error <= 1'b1;
          end
          S_NUM2: begin
            if (digit_ok) begin
              num2           <= entry_next[15:0];
              num2_has_digit <= 1'b1;
            end else begin
              entry_error <= 1'b1;
            end
          end
          S_RESULT: begin
            // A digit on a shown result starts a fresh calculation.
            num1           <= (IN_digit <= 4'd9) ? {12'd0, IN_digit} : 16'd0;
            entry_error    <= (IN_digit > 4'd9);
            num2           <= 16'd0;
            op             <= 3'b000;
            result         <= 32'd0;
            sign           <= 1'b0;
            num2_has_digit <= 1'b0;
            state          <= S_NUM1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    OUT_display          = 32'd0;
    OUT_display_negative = 1'b0;
    case (state)
      S_NUM1:   OUT_display = {16'd0, num1};
      S_NUM2,
      S_CALC:   OUT_display = {16'd0, num2};
      default: begin
        OUT_display          = result;
        OUT_display_negative = sign;
      end
    endcase
  end

  assign OUT_num1           = num1;
  assign OUT_num2           = num2;
  assign OUT_operation_code = op;
  assign OUT_state          = state;
  assign OUT_entry_error    = entry_error;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed key sequences, a behavioural datapath, and a result scoreboard.
// Build with +define+CALC_CHAIN_EN to exercise result chaining.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        op_valid;
  logic [2:0]  op_code_in;
  logic        equals;
  logic        clear;
  logic [31:0] answer;
  logic        is_negative;
  logic [15:0] num1;
  logic [15:0] num2;
  logic [2:0]  operation_code;
  logic [31:0] display;
  logic        display_negative;
  logic [1:0]  state;
  logic        entry_error;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  calc_sequencer dut (
    .IN_clk               (clk),
    .IN_reset             (reset),
    .IN_digit_valid       (digit_valid),
    .IN_digit             (digit),
    .IN_op_valid          (op_valid),
    .IN_op_code           (op_code_in),
    .IN_equals            (equals),
    .IN_clear             (clear),
    .IN_answer            (answer),
    .IN_is_negative       (is_negative),
    .OUT_num1             (num1),
    .OUT_num2             (num2),
    .OUT_operation_code   (operation_code),
    .OUT_display          (display),
    .OUT_display_negative (display_negative),
    .OUT_state            (state),
    .OUT_entry_error      (entry_error)
  );

  // Behavioural calculation datapath: subtraction reports magnitude plus sign.
  always_comb begin
    answer      = 32'd0;
    is_negative = 1'b0;
    case (operation_code)
      3'b001: answer = {16'd0, num1} + {16'd0, num2};
      3'b010: begin
        if (num1 >= num2) answer = {16'd0, num1} - {16'd0, num2};
        else begin
          answer      = {16'd0, num2} - {16'd0, num1};
          is_negative = 1'b1;
        end
      end
      3'b100: answer = {16'd0, num1} * {16'd0, num2};
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_digit(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    step();
    digit_valid = 1'b0;
  endtask

  task automatic press_op(input logic [2:0] c);
    op_valid   = 1'b1;
    op_code_in = c;
    step();
    op_valid   = 1'b0;
  endtask

  task automatic press_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Pushes the expected result, then checks the two-edge latency to S_RESULT.
  task automatic press_equals_expect(input logic [31:0] exp, input logic neg);
    exp_q.push_back({neg, exp});
    equals = 1'b1;
    step();
    equals = 1'b0;
    check("calc_state", 32'(state), 32'd2);
    step();
    check("result_latency", 32'(state), 32'd3);
  endtask

  // Monitor: each entry into S_RESULT is compared against the next expected result.
  initial begin
    logic [1:0]  prev;
    logic [32:0] e;
    prev = 2'd0;
    forever begin
      @(negedge clk);
      if (!reset && state == 2'd3 && prev != 2'd3) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0d expected none", display);
        end else begin
          e = exp_q.pop_front();
          check("result_display", display, e[31:0]);
          check("result_negative", 32'(display_negative), 32'(e[32]));
        end
      end
      prev = state;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; digit_valid = 1'b0; digit = 4'd0; op_valid = 1'b0;
    op_code_in = 3'b000; equals = 1'b0; clear = 1'b0;
    step();
    step();
    check("reset_state", 32'(state), 32'd0);
    check("reset_num1", 32'(num1), 32'd0);
    check("reset_num2", 32'(num2), 32'd0);
    check("reset_op", 32'(operation_code), 32'd0);
    check("reset_display", display, 32'd0);
    check("reset_negative", 32'(display_negative), 32'd0);
    check("reset_error", 32'(entry_error), 32'd0);
    reset = 1'b0;

    // 123 + 45 = 168
    press_digit(4'd1); press_digit(4'd2); press_digit(4'd3);
    check("num1_123", 32'(num1), 32'd123);
    check("op_in_num1", 32'(operation_code), 32'd0);
    press_op(3'b001);
    check("state_num2", 32'(state), 32'd1);
    check("op_latched", 32'(operation_code), 32'd1);
    press_digit(4'd4); press_digit(4'd5);
    check("display_num2", display, 32'd45);
    press_equals_expect(32'd168, 1'b0);

    // 5 - 9 = -4 (digit on a result starts a new entry)
    press_digit(4'd5);
    check("new_entry_state", 32'(state), 32'd0);
    check("new_entry_num1", 32'(num1), 32'd5);
    check("new_entry_op", 32'(operation_code), 32'd0);
    press_op(3'b010);
    press_digit(4'd9);
    press_equals_expect(32'd4, 1'b1);

    // Overflow rejection at 65536+
    press_digit(4'd6); press_digit(4'd5); press_digit(4'd5); press_digit(4'd3);
    press_digit(4'd6);
    check("overflow_error", 32'(entry_error), 32'd1);
    check("overflow_num1", 32'(num1), 32'd6553);
    step();
    check("error_one_cycle", 32'(entry_error), 32'd0);
    press_digit(4'd5);
    check("num1_max", 32'(num1), 32'd65535);
    press_op(3'b100);
    press_digit(4'd6); press_digit(4'd5); press_digit(4'd5); press_digit(4'd3); press_digit(4'd5);
    check("num2_max", 32'(num2), 32'd65535);
    press_equals_expect(32'd4294836225, 1'b0);
    press_op(3'b001);
`ifdef CALC_CHAIN_EN
    check("chain_big_error", 32'(entry_error), 32'd1);
`else
    check("no_chain_no_error", 32'(entry_error), 32'd0);
`endif
    check("op_on_result_state", 32'(state), 32'd3);

    // Operator replacement before any num2 digit; later operator ignored
    press_clear();
    check("clear_state", 32'(state), 32'd0);
    check("clear_num1", 32'(num1), 32'd0);
    press_digit(4'd8);
    press_op(3'b001);
    press_op(3'b100);
    check("op_replaced", 32'(operation_code), 32'd4);
    press_digit(4'd3);
    press_op(3'b001);
    check("op_not_replaced", 32'(operation_code), 32'd4);
    press_equals_expect(32'd24, 1'b0);

    // Invalid digit and non-one-hot operator
    press_clear();
    press_digit(4'd12);
    check("bad_digit_error", 32'(entry_error), 32'd1);
    check("bad_digit_num1", 32'(num1), 32'd0);
    press_op(3'b011);
    check("bad_op_error", 32'(entry_error), 32'd1);
    check("bad_op_state", 32'(state), 32'd0);

    // Clear together with equals in S_NUM2
    press_digit(4'd1); press_op(3'b001); press_digit(4'd2);
    clear = 1'b1; equals = 1'b1;
    step();
    clear = 1'b0; equals = 1'b0;
    check("clear_eq_state", 32'(state), 32'd0);
    check("clear_eq_num2", 32'(num2), 32'd0);
    check("clear_eq_op", 32'(operation_code), 32'd0);

    // Clear while in S_CALC discards the calculation
    press_digit(4'd1); press_op(3'b001); press_digit(4'd2);
    equals = 1'b1;
    step();
    equals = 1'b0;
    check("pre_clear_calc", 32'(state), 32'd2);
    press_clear();
    check("clear_calc_state", 32'(state), 32'd0);
    check("clear_calc_display", display, 32'd0);
    step(); step(); step();
    check("clear_calc_stays", 32'(state), 32'd0);

    // Equals wins over a simultaneous digit: 1 + 2 = 3
    press_digit(4'd1); press_op(3'b001); press_digit(4'd2);
    exp_q.push_back({1'b0, 32'd3});
    equals = 1'b1; digit_valid = 1'b1; digit = 4'd7;
    step();
    equals = 1'b0; digit_valid = 1'b0;
    check("prio_calc_state", 32'(state), 32'd2);
    step();
    check("prio_result_state", 32'(state), 32'd3);

    // 7 + 2 = 9, then chained * 3 = 27
    press_digit(4'd7); press_op(3'b001); press_digit(4'd2);
    press_equals_expect(32'd9, 1'b0);
    press_op(3'b100);
`ifdef CALC_CHAIN_EN
    check("chain_state", 32'(state), 32'd1);
    check("chain_num1", 32'(num1), 32'd9);
    check("chain_op", 32'(operation_code), 32'd4);
    press_digit(4'd3);
    press_equals_expect(32'd27, 1'b0);
`else
    check("no_chain_state", 32'(state), 32'd3);
    check("no_chain_error", 32'(entry_error), 32'd0);
    press_digit(4'd3);
    check("no_chain_new_num1", 32'(num1), 32'd3);
`endif

    step(); step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
